twiddle_table_loader: RTL
=========================

TWIDDLE_TABLE_LOADER -- requirements
Module: twiddle_table_loader

Interface
REQ-001 SHALL have parameter FFT_N, default 1024, FFT length; power of two, at least 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a table load.
REQ-005 SHALL have port s_valid  input  1  quarter-wave sample valid.
REQ-006 SHALL have port s_ready  output  1  loader accepts a sample.
REQ-007 SHALL have port s_data  input  16  signed Q1.15 sample q[i] = round(32767*sin(2*pi*i/FFT_N)), i = 0..FFT_N/4, sent in index order.
REQ-008 SHALL have port wr_en  output  1  table write strobe.
REQ-009 SHALL have port wr_addr  output  $clog2(FFT_N)-1  twiddle index k, 0..FFT_N/2-1.
REQ-010 SHALL have port wr_cos  output  16  signed W_re for index k.
REQ-011 SHALL have port wr_sin  output  16  signed W_im for index k (W = exp(-j*2*pi*k/FFT_N)).
REQ-012 SHALL have port busy  output  1  high in LOAD and EXPAND.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the final write is issued.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EXPAND; reset state IDLE.
REQ-015 SHALL move IDLE -> LOAD on the cycle after start=1 in IDLE; start in LOAD or EXPAND is ignored.
REQ-016 SHALL assert s_ready only in LOAD; a sample is accepted on an edge with s_valid=1 and s_ready=1; s_valid gaps insert wait cycles with no state change.
REQ-017 SHALL store accepted samples in an internal buffer of FFT_N/4+1 entries at index = acceptance count, index counter 0..FFT_N/4.
REQ-018 SHALL move LOAD -> EXPAND on the edge accepting sample index FFT_N/4; s_ready is low from the next cycle.
REQ-019 SHALL in EXPAND issue exactly FFT_N/2 writes on consecutive cycles, k = 0..FFT_N/2-1 ascending, with no gaps.
REQ-020 SHALL assert wr_en for index k exactly k+2 cycles after the final-sample acceptance edge; the cycle between is the buffer-read pipeline stage.
REQ-021 SHALL output, for 0 <= k <= FFT_N/4: wr_cos = q[FFT_N/4-k], wr_sin = -q[k].
REQ-022 SHALL output, for FFT_N/4 < k < FFT_N/2: wr_cos = -q[k-FFT_N/4], wr_sin = -q[FFT_N/2-k].
REQ-023 SHALL compute negation as 16-bit two's complement, saturated so that -(-32768) yields 32767.
REQ-024 SHALL hold wr_addr, wr_cos and wr_sin stable and registered while wr_en=1; their values while wr_en=0 are don't-care.
REQ-025 SHALL pulse done coincident with the wr_en cycle for k = FFT_N/2-1, then return to IDLE on the next edge.
REQ-026 SHALL accept start on the first cycle back in IDLE, so back-to-back loads are allowed.

Reset
REQ-027 SHALL on rst_n=0 immediately force s_ready=0, wr_en=0, done=0, busy=0, state IDLE, and all counters to 0, independent of clk.
REQ-028 SHALL treat reset in LOAD or EXPAND as abort: no further writes and no done pulse; buffer contents need not be cleared.
REQ-029 SHALL stay in IDLE after rst_n deasserts until a new start.

Verification (FFT_N=16; q = 0, 12539, 23170, 30273, 32767)
REQ-030 SHALL cover nominal load: start, 5 samples back-to-back -> 8 contiguous writes starting 2 cycles after the 5th accept; k0 (32767,0), k4 (0,-32767), k5 (-12539,-30273), k7 (-30273,-12539); done with k7.
REQ-031 SHALL cover stalled input: s_valid low 3 cycles between samples 2 and 3 -> s_ready stays high, no writes, same final table as nominal.
REQ-032 SHALL cover ignored start: start pulsed during LOAD and during EXPAND -> exactly 8 writes and one done per load.
REQ-033 SHALL cover reset abort: rst_n low during EXPAND after the k=3 write -> wr_en/done/busy 0 with no clock edge needed; no done; the next start loads normally.
REQ-034 SHALL cover saturation: q[2] = -32768 -> k2 wr_sin = 32767, k6 wr_cos = 32767.
REQ-035 SHALL cover back-to-back: start on the first IDLE cycle after done -> second load completes identically.

Source files
------------

// File: rtl/twiddle_table_loader.sv
// Twiddle table loader: expands a quarter-wave sine table into
// W = exp(-j*2*pi*k/N) entries for k = 0..N/2-1.
module twiddle_table_loader #(
  parameter int FFT_N = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [15:0]        s_data,
  output logic                      wr_en,
  output logic [$clog2(FFT_N)-2:0]  wr_addr,
  output logic signed [15:0]        wr_cos,
  output logic signed [15:0]        wr_sin,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(FFT_N) - 1;
  localparam int Q  = FFT_N / 4;
  localparam int IW = $clog2(Q + 1);

  localparam logic [IW-1:0] QI   = IW'(Q);
  localparam logic [AW:0]   KQ   = (AW+1)'(Q);
  localparam logic [AW:0]   KH   = (AW+1)'(FFT_N / 2);
  localparam logic [AW-1:0] LAST = AW'(FFT_N / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND
  } state_t;

  state_t state;

  logic signed [15:0] mem [0:Q];

  logic [IW-1:0]      cnt;
  logic [AW:0]        rk;
  logic               p_valid;
  logic               p_cneg;
  logic [AW-1:0]      p_addr;
  logic signed [15:0] p_cos;
  logic signed [15:0] p_sin;

  logic               accept;
  logic               upper;
  logic [IW-1:0]      ia;
  logic [IW-1:0]      ib;

  // Two's complement negate that maps -32768 to +32767.
  function automatic logic signed [15:0] neg16(
    input logic signed [15:0] x
  );
    return (x == 16'sh8000) ? 16'sh7fff : -x;
  endfunction

  // Quadrant folding: buffer indices for the cos and sin terms of rk.
  always_comb begin
    accept = s_valid & s_ready;
    upper  = (rk > KQ);
    ia     = upper ? IW'(rk - KQ) : IW'(KQ - rk);
    ib     = upper ? IW'(KH - rk) : IW'(rk);
  end

  // Quarter-wave sample buffer, written in acceptance order.
  always_ff @(posedge clk) begin
    if (accept)
      mem[cnt] <= s_data;
  end

  // Control FSM, buffer-read stage and registered write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      rk      <= '0;
      p_valid <= 1'b0;
      p_cneg  <= 1'b0;
      p_addr  <= '0;
      p_cos   <= '0;
      p_sin   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_cos  <= '0;
      wr_sin  <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= p_valid;
      done  <= p_valid && (p_addr == LAST);
      if (p_valid) begin
        wr_addr <= p_addr;
        wr_cos  <= p_cneg ? neg16(p_cos) : p_cos;
        wr_sin  <= neg16(p_sin);
      end
      p_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (cnt == QI) begin
              state   <= EXPAND;
              s_ready <= 1'b0;
              rk      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXPAND: begin
          if (rk != KH) begin
            p_valid <= 1'b1;
            p_addr  <= rk[AW-1:0];
            p_cneg  <= upper;
            p_cos   <= mem[ia];
            p_sin   <= mem[ib];
            rk      <= rk + 1'b1;
          end
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
